// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel format and rectangle-fill state encoding.
// Scan-out timing uses the same H_RES/V_RES.
package fb_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 16;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fb_state_t;

    // Linear offset of a line start; 640 = 512 + 128, so two shifts and an add.
    function automatic logic [ADDR_W-1:0] line_offset(input logic [COORD_W-1:0] y);
        if (H_RES == 640)
            return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7);
        else
            return ADDR_W'(y) * ADDR_W'(H_RES);
    endfunction

endpackage

// File: rtl/fb_clip.sv
// Combinational clip of a fill rectangle against the visible frame, with
// empty-rectangle detection.
module fb_clip
    import fb_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [COORD_W:0]   x_end,
    output logic [COORD_W:0]   y_end,
    output logic               empty
);

    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    logic [COORD_W:0] x_sum;
    logic [COORD_W:0] y_sum;

    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_end = (y_sum > V_LIM) ? V_LIM : y_sum;
        empty = (w == '0) || (h == '0) || ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill writer: takes one fill command at a time and writes the
// clipped rectangle into frame RAM port A, one pixel per clock in raster order.
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [DATA_W-1:0]  cmd_color,
    output logic               busy,
    output logic               done,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_din
);

    fb_state_t state, state_nxt;

    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
    logic [COORD_W-1:0] x_nxt, y_nxt, w_nxt, h_nxt;
    logic [DATA_W-1:0]  color_q, color_nxt;
    logic [COORD_W-1:0] cur_x, cur_y, cur_x_nxt, cur_y_nxt;
    logic [ADDR_W-1:0]  row_base, row_base_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  din_nxt;
    logic               we_nxt, done_nxt;

    logic [COORD_W:0]   x_end, y_end;
    logic               empty;
    logic               last_col, last_row;

    fb_clip u_clip (
        .x     (x_q),
        .y     (y_q),
        .w     (w_q),
        .h     (h_q),
        .x_end (x_end),
        .y_end (y_end),
        .empty (empty)
    );

    assign last_col = ({1'b0, cur_x} + (COORD_W+1)'(1)) == x_end;
    assign last_row = ({1'b0, cur_y} + (COORD_W+1)'(1)) == y_end;
    assign mem_en   = mem_we;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Write outputs are computed one cycle ahead so the strobe, address and
    // data all come straight from flops in the cycle they are used.
    always_comb begin
        state_nxt    = state;
        x_nxt        = x_q;
        y_nxt        = y_q;
        w_nxt        = w_q;
        h_nxt        = h_q;
        color_nxt    = color_q;
        cur_x_nxt    = cur_x;
        cur_y_nxt    = cur_y;
        row_base_nxt = row_base;
        we_nxt       = 1'b0;
        addr_nxt     = mem_addr;
        din_nxt      = mem_din;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    x_nxt     = cmd_x;
                    y_nxt     = cmd_y;
                    w_nxt     = cmd_w;
                    h_nxt     = cmd_h;
                    color_nxt = cmd_color;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (empty) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    row_base_nxt = line_offset(y_q);
                    cur_x_nxt    = x_q;
                    cur_y_nxt    = y_q;
                    we_nxt       = 1'b1;
                    addr_nxt     = line_offset(y_q) + ADDR_W'(x_q);
                    din_nxt      = color_q;
                    state_nxt    = FILL;
                end
            end
            FILL: begin
                if (last_col && last_row) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (last_col) begin
                    cur_x_nxt    = x_q;
                    cur_y_nxt    = cur_y + COORD_W'(1);
                    row_base_nxt = row_base + ADDR_W'(H_RES);
                    we_nxt       = 1'b1;
                    addr_nxt     = row_base + ADDR_W'(H_RES) + ADDR_W'(x_q);
                end else begin
                    cur_x_nxt = cur_x + COORD_W'(1);
                    we_nxt    = 1'b1;
                    addr_nxt  = mem_addr + ADDR_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            row_base  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            w_q       <= w_nxt;
            h_q       <= h_nxt;
            color_q   <= color_nxt;
            cur_x     <= cur_x_nxt;
            cur_y     <= cur_y_nxt;
            row_base  <= row_base_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_din   <= din_nxt;
            done      <= done_nxt;
            busy      <= (state_nxt != IDLE);
            cmd_ready <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed vector table, hand-written
// multi-cycle sequences and random commands against a pixel-list model.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [15:0] cmd_color = '0;
    logic        busy, done, mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [15:0] mem_din;

    fb_rect_fill dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x, y, w, h;
        logic [15:0] color;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   n;
        int   first;
        int   last;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int unsigned exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: every visible pixel of the rectangle, in raster order.
    task automatic build_expected(input cmd_t c);
        exp_q.delete();
        for (int yy = int'(c.y); yy < int'(c.y) + int'(c.h); yy++)
            if (yy < 480)
                for (int xx = int'(c.x); xx < int'(c.x) + int'(c.w); xx++)
                    if (xx < 640) exp_q.push_back(yy * 640 + xx);
    endtask

    // Called at a falling edge; returns at the falling edge where cmd_ready is back.
    task automatic run_cmd(input cmd_t c, input bit hold, input cmd_t nxt,
                           output int waited, output int n_wr, output int first_a, output int last_a);
        n_wr = 0; first_a = -1; last_a = -1; waited = 0;
        build_expected(c);
        cmd_x = c.x; cmd_y = c.y; cmd_w = c.w; cmd_h = c.h; cmd_color = c.color;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) begin
            cmd_x = nxt.x; cmd_y = nxt.y; cmd_w = nxt.w; cmd_h = nxt.h; cmd_color = nxt.color;
        end else begin
            cmd_valid = 1'b0;
        end
        check("setup_flags", {busy, mem_we, mem_en, cmd_ready, done}, 5'b10000);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check("wr_flags", {mem_we, mem_en, busy, cmd_ready, done}, 5'b11100);
            check("wr_addr", mem_addr, exp_q[i]);
            check("wr_din", mem_din, c.color);
            if (mem_we) begin
                if (n_wr == 0) first_a = int'(mem_addr);
                last_a = int'(mem_addr);
                n_wr++;
            end
        end
        @(negedge clk);
        check("done_flags", {done, busy, mem_we, mem_en, cmd_ready}, 5'b11000);
        @(negedge clk);
        check("ready_flags", {cmd_ready, done, busy, mem_we}, 4'b1000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        cmd_t c, c2, none;
        int waited, n, f, l, cnt, t;

        none = '{x: '0, y: '0, w: '0, h: '0, color: '0};
        tbl[0] = '{c: '{x: 10,  y: 20,  w: 3,  h: 2,  color: 16'h0F00}, n: 6, first: 12810,  last: 13452};
        tbl[1] = '{c: '{x: 638, y: 479, w: 5,  h: 4,  color: 16'hABCD}, n: 2, first: 307198, last: 307199};
        tbl[2] = '{c: '{x: 5,   y: 5,   w: 0,  h: 5,  color: 16'h1111}, n: 0, first: -1,     last: -1};
        tbl[3] = '{c: '{x: 640, y: 0,   w: 10, h: 10, color: 16'h2222}, n: 0, first: -1,     last: -1};
        tbl[4] = '{c: '{x: 0,   y: 0,   w: 10, h: 0,  color: 16'h3333}, n: 0, first: -1,     last: -1};
        tbl[5] = '{c: '{x: 0,   y: 480, w: 4,  h: 4,  color: 16'h4444}, n: 0, first: -1,     last: -1};
        tbl[6] = '{c: '{x: 639, y: 479, w: 1,  h: 1,  color: 16'h5555}, n: 1, first: 307199, last: 307199};
        tbl[7] = '{c: '{x: 0,   y: 0,   w: 1,  h: 1,  color: 16'h6666}, n: 1, first: 0,      last: 0};
        tbl[8] = '{c: '{x: 100, y: 0,   w: 4,  h: 1,  color: 16'hFFFF}, n: 4, first: 100,    last: 103};
        tbl[9] = '{c: '{x: 637, y: 2,   w: 9,  h: 2,  color: 16'h0001}, n: 6, first: 1917,   last: 2559};

        // Reset held three cycles: every output low, no write strobe.
        repeat (3) begin
            @(negedge clk);
            check("rst_flags", {cmd_ready, busy, done, mem_en, mem_we}, 5'b00000);
            check("rst_addr_din", {mem_addr, mem_din}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {cmd_ready, busy, done, mem_we}, 4'b1000);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].c, 1'b0, none, waited, n, f, l);
            check("tbl_count", n, tbl[i].n);
            check("tbl_first", f, tbl[i].first);
            check("tbl_last", l, tbl[i].last);
        end

        // Back-to-back: second command held valid through the whole first one.
        c  = '{x: 300, y: 200, w: 3, h: 3, color: 16'hBEEF};
        c2 = '{x: 50,  y: 60,  w: 2, h: 2, color: 16'hCAFE};
        run_cmd(c, 1'b1, c2, waited, n, f, l);
        check("b2b_first_count", n, 9);
        run_cmd(c2, 1'b0, none, waited, n, f, l);
        check("b2b_accept_wait", waited, 0);
        check("b2b_second_first", f, 60 * 640 + 50);

        // Random commands, biased to cross the right and bottom edges.
        for (int k = 0; k < 40; k++) begin
            c.x = 10'($urandom_range(0, 660));
            c.y = 10'($urandom_range(0, 490));
            c.w = 10'($urandom_range(0, 9));
            c.h = 10'($urandom_range(0, 6));
            c.color = 16'($urandom);
            run_cmd(c, 1'b0, none, waited, n, f, l);
            check("rnd_count", n, exp_q.size());
        end

        // Reset during a full-frame fill at the 100th write.
        c = '{x: 0, y: 0, w: 640, h: 480, color: 16'h7E7E};
        cmd_x = c.x; cmd_y = c.y; cmd_w = c.w; cmd_h = c.h; cmd_color = c.color;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0; t = 0;
        while (cnt < 100 && t < 300) begin
            @(negedge clk);
            t++;
            if (mem_we) cnt++;
        end
        check("midfill_writes_seen", cnt, 100);
        check("midfill_100th_addr", mem_addr, 99);
        rst = 1'b1;
        @(negedge clk);
        check("midfill_rst_flags", {mem_we, mem_en, done, busy, cmd_ready}, 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        check("midfill_ready", {cmd_ready, done, mem_we}, 3'b100);
        c = '{x: 0, y: 0, w: 1, h: 1, color: 16'h0042};
        run_cmd(c, 1'b0, none, waited, n, f, l);
        check("post_rst_count", n, 1);
        check("post_rst_addr", f, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Framebuffer rectangle-fill writer: accepts a fill command (x, y, width, height, colour) over a valid/ready handshake and writes the clipped rectangle into the video frame RAM one pixel per clock. It drives the write port (port A) of the dual-port frame RAM, while the VGA scan-out reads the other port. It is the first producer of framebuffer content; clear-screen is a full-frame fill.

## Interface
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- ADDR_W, 19, frame RAM address width (H_RES*V_RES ≤ 2^ADDR_W)
- DATA_W, 16, pixel word width
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x, cmd_y  in  10 each  top-left corner, pixels
- cmd_w, cmd_h  in  10 each  extent, pixels; 0 = empty
- cmd_color  in  DATA_W  pixel value to write
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command finishes
- mem_en  out  1  RAM port enable (equals mem_we)
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  linear address y*H_RES + x
- mem_din  out  DATA_W  write data

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all cmd_* fields -> SETUP.
- SETUP (1 cycle): clip. x_end = min(x+w, H_RES), y_end = min(y+h, V_RES), sums 11-bit unsigned, no overflow. Empty if w==0, h==0, x≥H_RES or y≥V_RES -> DONE, no writes. Otherwise row_base = y*H_RES via shift-add (640: (y<<9)+(y<<7)); cur_x=x, cur_y=y -> FILL.
- FILL: each cycle mem_we=mem_en=1, mem_addr=row_base+cur_x, mem_din=latched colour. Raster order: left to right, top to bottom. At cur_x==x_end-1: cur_x=x, cur_y+1, row_base+=H_RES (no multiplier in loop). Last pixel (x_end-1, y_end-1) -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- busy=1 in SETUP, FILL, DONE. cmd_ready=(state==IDLE). Commands arriving while busy stall (held by producer), never dropped or queued.
- No read-modify-write; the RAM's write-port read data is unused.

## Timing
- Reset: state IDLE; cmd_ready=1 on the first cycle after rst deasserts (0 while rst high); busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Accept at cycle T; SETUP at T+1; first write at T+2; N clipped pixels written at T+2..T+1+N, exactly one per cycle, no bubbles; done at T+2+N; cmd_ready again at T+3+N.
- Empty command: done at T+2, cmd_ready at T+3, no mem_we.
- All outputs registered; mem_we/mem_addr/mem_din valid in the same cycle.
- rst mid-FILL: next cycle state IDLE, mem_we=0, no done pulse; partial rectangle stays in RAM.
- Max 640*480=307200 writes per command; the RAM write clock equals clk.

## Structure
- Shared package fb_pkg: H_RES, V_RES, ADDR_W, DATA_W, state enum {IDLE, SETUP, FILL, DONE}; vga_mem timing uses the same H_RES/V_RES.
- Single module; optional sub-module fb_clip (combinational clip + empty detect) for separate unit test.

## Test plan
- Reset: hold rst 3 cycles -> all outputs 0 during rst; cmd_ready=1 the cycle after release; no mem_we ever.
- Basic fill: x=10, y=20, w=3, h=2, colour 0x0F00 -> writes to 12810, 12811, 12812, 13450, 13451, 13452 on consecutive cycles starting T+2; done at T+8.
- Clipping: x=638, y=479, w=5, h=4 -> writes only 307198, 307199; done at T+4.
- Empty/off-screen: w=0; and x=640, y=0, w=10, h=10 -> no writes, done at T+2, cmd_ready at T+3.
- Back-to-back: second command held valid during first -> accepted exactly at cycle cmd_ready rises; no write overlap; done pulses once per command.
- Reset mid-fill: full-frame fill, rst at 100th write -> mem_we=0 next cycle, no done; a new 1x1 command at (0,0) then writes address 0 once.
